// File: rtl/mem_responder.sv
// Word-array memory responder with a req/ack handshake and LATENCY wait states.
// Serves word, byte and halfword accesses; bad requests answer with err=1.
module mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  // Handshake: req is sampled only while idle; ack is a one-cycle pulse carrying
  // err and rdata, and busy covers the cycle after acceptance through the ack cycle.

  localparam int         IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        go_resp;
  logic        cur_wr;
  logic [31:0] cur_addr;
  logic [1:0]  cur_size;
  logic [31:0] cur_wdata;
  logic        req_err;
  logic [IW-1:0] idx;
  logic [31:0] mem_word;
  logic [31:0] rd_shift;
  logic [31:0] rd_mask;
  logic [31:0] rd_val;
  logic [3:0]  be;
  logic [31:0] wd;

  // With LATENCY=0 the response edge is the acceptance edge, so the live inputs
  // must be used while idle instead of the not-yet-captured copies.
  always_comb begin
    cur_wr    = wr_q;
    cur_addr  = addr_q;
    cur_size  = size_q;
    cur_wdata = wdata_q;
    if (state == S_IDLE) begin
      cur_wr    = wr;
      cur_addr  = addr;
      cur_size  = size;
      cur_wdata = wdata;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    go_resp  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          accept = 1'b1;
          cnt_nx = CNT_LOAD;
          if (LATENCY == 0) begin
            state_nx = S_RESP;
            go_resp  = 1'b1;
          end else begin
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = S_RESP;
          go_resp  = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req_err = (cur_size == 2'b11)
           || (cur_size == 2'b00 && cur_addr[1:0] != 2'b00)
           || (cur_size == 2'b10 && cur_addr[0])
           || ({2'b00, cur_addr[31:2]} >= 32'(DEPTH));
    idx      = cur_addr[IW+1:2];
    mem_word = req_err ? 32'd0 : mem[idx];
    rd_shift = mem_word >> {cur_addr[1:0], 3'b000};
    rd_mask  = 32'd0;
    be       = 4'b0000;
    wd       = cur_wdata;
    case (cur_size)
      2'b00: begin
        rd_mask = 32'hFFFF_FFFF;
        be      = 4'b1111;
      end
      2'b01: begin
        rd_mask = 32'h0000_00FF;
        be      = 4'b0001 << cur_addr[1:0];
        wd      = {4{cur_wdata[7:0]}};
      end
      2'b10: begin
        rd_mask = 32'h0000_FFFF;
        be      = cur_addr[1] ? 4'b1100 : 4'b0011;
        wd      = {2{cur_wdata[15:0]}};
      end
      default: begin
        rd_mask = 32'd0;
        be      = 4'b0000;
      end
    endcase
    rd_val = rd_shift & rd_mask;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      size_q  <= 2'b00;
      wdata_q <= 32'd0;
      rdata   <= 32'd0;
      ack     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        wr_q    <= wr;
        addr_q  <= addr;
        size_q  <= size;
        wdata_q <= wdata;
      end
      ack   <= go_resp;
      err   <= go_resp && req_err;
      rdata <= (go_resp && !req_err && !cur_wr) ? rd_val : 32'd0;
      busy  <= (state_nx != S_IDLE);
    end
  end

  // Array has no reset; a reset edge suppresses the commit so aborted writes vanish.
  always_ff @(posedge clk) begin
    if (reset && go_resp && cur_wr && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed plan items plus random traffic, checked
// against a byte-addressed model; a second instance covers LATENCY=0.
module tb_mem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req, wr;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  size;
  logic        ack, err, busy;

  logic        req0, wr0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [1:0]  size0;
  logic        ack0, err0, busy0;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .size(size),
    .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
  );

  mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .wr(wr0), .addr(addr0), .size(size0),
    .wdata(wdata0), .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int fails     = 0;
  logic [32:0] exp_q[$];            // {err, rdata}
  logic [7:0]  model_mem [4*DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'b11) || (s == 2'b00 && a[1:0] != 2'b00) ||
           (s == 2'b10 && a[0]) || (a >= 32'(4*DEPTH));
  endfunction

  // Byte-level view of the memory: an access touches 4, 1 or 2 consecutive bytes.
  task automatic model_apply(input logic w, input logic [31:0] a, input logic [1:0] s,
                             input logic [31:0] d, output logic [32:0] e);
    int n;
    logic [31:0] r;
    r = 32'd0;
    n = (s == 2'b00) ? 4 : (s == 2'b01) ? 1 : 2;
    if (model_err(a, s)) begin
      e = {1'b1, 32'd0};
    end else if (w) begin
      for (int i = 0; i < n; i++) model_mem[a + i] = d[8*i +: 8];
      e = {1'b0, 32'd0};
    end else begin
      for (int i = 0; i < n; i++) r[8*i +: 8] = model_mem[a + i];
      e = {1'b0, r};
    end
  endtask

  // ---------------- driver ----------------
  // Called and returns at a negedge. poke=1 raises req again during WAIT.
  task automatic txn(input logic w, input logic [31:0] a, input logic [1:0] s,
                     input logic [31:0] d, input bit poke = 1'b0);
    logic [32:0] e;
    int n, nbusy;
    model_apply(w, a, s, d, e);
    exp_q.push_back(e);
    req = 1'b1; wr = w; addr = a; size = s; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = poke; wr = 1'($urandom); addr = $urandom; size = 2'($urandom); wdata = $urandom;
    n = 1;
    nbusy = 0;
    while (ack !== 1'b1 && n < 20) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      req = 1'b0;
      n++;
    end
    e = exp_q.pop_front();
    if (ack !== 1'b1) begin
      check("ack_timeout", 32'(ack), 32'd1);
    end else begin
      if (busy === 1'b1) nbusy++;
      check("latency", 32'(n), 32'(LAT + 1));
      check("busy_cycles", 32'(nbusy), 32'(LAT + 1));
      check("err", 32'(err), 32'(e[32]));
      check("rdata", rdata, e[31:0]);
    end
    req = 1'b0;
    @(negedge clk);
    check("ack_pulse", 32'(ack), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("err_idle", 32'(err), 32'd0);
    check("rdata_idle", rdata, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] vals [4];
    logic [31:0] a;
    logic [1:0]  s;
    logic        w;

    for (int i = 0; i < 4*DEPTH; i++) model_mem[i] = 8'h00;

    // Reset held with req high: nothing accepted, all outputs low.
    reset = 1'b0; req = 1'b1; wr = 1'b0; addr = 32'h10; size = 2'b00; wdata = 32'h0;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h0; size0 = 2'b00; wdata0 = 32'h0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_ack0", 32'(ack0), 32'd0);
    end
    reset = 1'b1; req = 1'b0; req0 = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Bring the array to a known all-zero state.
    for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'(4*i), 2'b00, 32'd0);

    // Latency and basic word access.
    txn(1'b1, 32'h10, 2'b00, 32'hDEAD_BEEF);
    txn(1'b0, 32'h10, 2'b00, 32'h0);

    // Byte / halfword lanes.
    txn(1'b1, 32'h20, 2'b00, 32'h1122_3344);
    txn(1'b1, 32'h21, 2'b01, 32'hFFFF_FFAA);
    txn(1'b0, 32'h20, 2'b00, 32'h0);
    txn(1'b0, 32'h22, 2'b10, 32'h0);
    txn(1'b0, 32'h23, 2'b01, 32'h0);

    // Error cases.
    txn(1'b0, 32'h02, 2'b00, 32'h0);
    txn(1'b1, 32'h21, 2'b10, 32'h0000_BEEF);
    txn(1'b0, 32'h20, 2'b00, 32'h0);
    txn(1'b0, 32'h100, 2'b00, 32'h0);
    txn(1'b0, 32'h04, 2'b11, 32'h0);

    // req during WAIT is ignored: exactly one ack.
    txn(1'b0, 32'h10, 2'b00, 32'h0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("poke_no_extra_ack", 32'(ack), 32'd0);
    end

    // Reset during WAIT of a write aborts it.
    txn(1'b1, 32'h30, 2'b00, 32'h5);
    req = 1'b1; wr = 1'b1; addr = 32'h30; size = 2'b00; wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("abort_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_busy_clr", 32'(busy), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_no_ack", 32'(ack), 32'd0);
    end
    txn(1'b0, 32'h30, 2'b00, 32'h0);

    // Random traffic, mostly aligned, some beyond the array.
    for (int k = 0; k < 200; k++) begin
      a = 32'($urandom_range(0, 4*DEPTH + 15));
      s = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'b00) a[1:0] = 2'b00;
        if (s == 2'b10) a[0] = 1'b0;
      end
      txn(w, a, s, $urandom);
    end

    // LATENCY=0: req held high, one request every other cycle.
    for (int k = 0; k < 8; k++) begin
      if (k < 4) vals[k] = $urandom;
      req0 = 1'b1; wr0 = (k < 4); addr0 = 32'(4*(k % 4)); size0 = 2'b00;
      wdata0 = (k < 4) ? vals[k] : $urandom;
      @(negedge clk);
      check("l0_ack", 32'(ack0), 32'd1);
      check("l0_err", 32'(err0), 32'd0);
      check("l0_rdata", rdata0, (k < 4) ? 32'd0 : vals[k % 4]);
      @(negedge clk);
      check("l0_gap", 32'(ack0), 32'd0);
    end
    req0 = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's data/instruction port. It serves word, byte and halfword read/write requests against an internal word array, with a fixed, parameterised number of wait states.
- It replaces the zero-wait memory with a req/ack handshake, so the control FSM can be verified against realistic memory latency.
- It uses the same size encoding as the core's MemDataSize select: 00 word, 01 byte, 10 halfword.

Parameters:
- DEPTH, 64, number of 32-bit words stored; byte addresses 0 .. 4*DEPTH-1 are valid.
- LATENCY, 2, wait-state cycles between request acceptance and the response cycle (0..15).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- req  input  1  request strobe; sampled only in IDLE.
- wr  input  1  1 = write, 0 = read; captured with req.
- addr  input  32  byte address; captured with req.
- size  input  2  access size: 00 word, 01 byte, 10 halfword, 11 illegal.
- wdata  input  32  write data, right-aligned (byte in [7:0], halfword in [15:0]).
- rdata  output  32  read data, zero-extended; valid only while ack=1.
- ack  output  1  one-cycle response pulse.
- err  output  1  valid with ack; 1 = request rejected.
- busy  output  1  1 from the cycle after acceptance through the ack cycle.

Behaviour:
- Reset (reset=0 at an edge):
  - State goes to IDLE; counter goes to 0; rdata, ack, err and busy go to 0.
  - Array contents are not cleared; simulation initialises the array to zero.
  - Reset mid-operation aborts the request; a pending write is never committed.
- FSM states: IDLE, WAIT, RESP.
  - IDLE with req=1: capture wr, addr, size and wdata; go to WAIT if LATENCY>0, else to RESP; counter loads LATENCY-1.
  - IDLE with req=0: stay in IDLE.
  - WAIT: decrement the counter each cycle; go to RESP when the counter is 0. Exactly LATENCY cycles are spent in WAIT.
  - RESP: ack=1 for exactly one cycle, then IDLE.
- Latency: ack is asserted LATENCY+1 cycles after the acceptance edge.
- The earliest next acceptance is the cycle after ack (one IDLE cycle between requests).
- req while busy=1 is ignored: no queueing, no side effects.
- Captured fields are immune to input changes after acceptance.
- Word index = addr[31:2]; lane = addr[1:0]; lane 0 = bits [7:0] (little-endian lanes).
- Error checks, evaluated on the captured request:
  - size=11 is an error.
  - word with addr[1:0]!=0 is an error.
  - halfword with addr[0]=1 is an error.
  - word index >= DEPTH is an error.
  - On error: no array write, rdata=0, err=1 with ack.
- Write, committed at the edge entering RESP:
  - word: replaces all 32 bits.
  - byte: replaces only lane addr[1:0] with wdata[7:0].
  - halfword: replaces lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - Other bytes of the word are untouched.
  - Write responses return rdata=0.
- Read, data registered at the edge entering RESP:
  - word: the full word.
  - byte: {24'd0, selected byte}.
  - halfword: {16'd0, selected halfword}.
- Outside RESP, ack=0, err=0 and rdata=0.
- A read issued after a write to the same address returns the new data (no stale path).

Test Plan:
- Reset: hold reset=0 for 2 cycles with req=1 → ack, busy, err, rdata all 0; no request accepted.
- Latency: LATENCY=2, write word 0xDEADBEEF at 0x10, then read 0x10 → each ack arrives exactly 3 cycles after acceptance; read rdata=0xDEADBEEF, err=0; busy=1 for 3 cycles per request.
- Byte/halfword lanes: word 0x11223344 at 0x20; write byte 0xAA at 0x21; read word → 0x1122AA44; read halfword at 0x22 → 0x00001122; read byte at 0x23 → 0x00000011.
- Errors:
  - word read at 0x02 → err=1, rdata=0.
  - halfword write at 0x21 → err=1 and the word at 0x20 is unchanged.
  - read at 0x100 (index 64) → err=1.
  - size=11 → err=1.
- Busy/abort:
  - Pulse req during WAIT → ignored; exactly one ack.
  - Assert reset during WAIT of a write to 0x30 holding 0x5 → no ack; a later read of 0x30 returns 0x5.
- LATENCY=0 back-to-back: req held high continuously → acks on alternating cycles, each 1 cycle after its acceptance.
